// File: rtl/rv32_scoreboard_if.sv
// Issue/retire bundle between decode, writeback and the register-write scoreboard.
// The slave side is the scoreboard; the master side is the pipeline driving it.
interface rv32_scoreboard_if;
    logic       stall_in;
    logic       flush_in;
    logic       issue_valid_in;
    logic [4:0] rs1_in;
    logic       rs1_read_in;
    logic [4:0] rs2_in;
    logic       rs2_read_in;
    logic [4:0] rd_in;
    logic       rd_write_in;
    logic       retire_valid_in;
    logic [4:0] retire_rd_in;
    logic       hazard_out;
    logic       issue_ready_out;
    logic       idle_out;
    logic       error_out;

    modport slave (
        input  stall_in, flush_in, issue_valid_in,
        input  rs1_in, rs1_read_in, rs2_in, rs2_read_in, rd_in, rd_write_in,
        input  retire_valid_in, retire_rd_in,
        output hazard_out, issue_ready_out, idle_out, error_out
    );

    modport master (
        output stall_in, flush_in, issue_valid_in,
        output rs1_in, rs1_read_in, rs2_in, rs2_read_in, rd_in, rd_write_in,
        output retire_valid_in, retire_rd_in,
        input  hazard_out, issue_ready_out, idle_out, error_out
    );
endinterface

// File: rtl/rv32_scoreboard.sv
// Register-write scoreboard: one saturating in-flight counter per architectural
// register, holding issue on pending sources or a saturated destination.
module rv32_scoreboard #(
    parameter int COUNT_WIDTH = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    rv32_scoreboard_if.slave   sb
);

    localparam logic [COUNT_WIDTH-1:0] CountMax = '1;
    localparam logic [COUNT_WIDTH-1:0] CountOne = COUNT_WIDTH'(1);

    logic [COUNT_WIDTH-1:0] countQ [32];
    logic [COUNT_WIDTH-1:0] countD [32];
    logic                   errorQ;
    logic                   errorD;

    logic rs1Busy;
    logic rs2Busy;
    logic rdFull;
    logic hazard;
    logic incEn;
    logic retEn;
    logic retUnderflow;
    logic anyBusy;

    // Hazard looks only at registered counts; a same-cycle retire does not bypass.
    always_comb begin
        rs1Busy = sb.rs1_read_in && (sb.rs1_in != 5'd0) && (countQ[sb.rs1_in] != '0);
        rs2Busy = sb.rs2_read_in && (sb.rs2_in != 5'd0) && (countQ[sb.rs2_in] != '0);
        rdFull  = sb.rd_write_in && (sb.rd_in  != 5'd0) && (countQ[sb.rd_in]  == CountMax);
        hazard  = rs1Busy || rs2Busy || rdFull;
        incEn   = sb.issue_valid_in && !hazard && !sb.stall_in && !sb.flush_in
                  && sb.rd_write_in && (sb.rd_in != 5'd0);
        retEn   = sb.retire_valid_in && (sb.retire_rd_in != 5'd0) && !sb.flush_in;
    end

    // An increment landing on the same register cancels the retire, so a retire
    // at count 0 is only an error when nothing is being issued to that register.
    always_comb begin
        retUnderflow = retEn && (countQ[sb.retire_rd_in] == '0)
                       && !(incEn && (sb.rd_in == sb.retire_rd_in));
        errorD       = errorQ || retUnderflow;
    end

    always_comb begin
        countD[0] = '0;
        for (int i = 1; i < 32; i++) begin
            logic incHere;
            logic decHere;
            incHere   = incEn && (sb.rd_in == 5'(i));
            decHere   = retEn && (sb.retire_rd_in == 5'(i));
            countD[i] = countQ[i];
            if (sb.flush_in) begin
                countD[i] = '0;
            end else if (incHere && !decHere) begin
                countD[i] = countQ[i] + CountOne;
            end else if (decHere && !incHere && (countQ[i] != '0)) begin
                countD[i] = countQ[i] - CountOne;
            end
        end
    end

    always_comb begin
        anyBusy = 1'b0;
        for (int i = 1; i < 32; i++) begin
            anyBusy = anyBusy || (countQ[i] != '0);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) begin
                countQ[i] <= '0;
            end
            errorQ <= 1'b0;
        end else begin
            for (int i = 0; i < 32; i++) begin
                countQ[i] <= countD[i];
            end
            errorQ <= errorD;
        end
    end

    assign sb.hazard_out      = hazard;
    assign sb.issue_ready_out = !hazard;
    assign sb.idle_out        = !anyBusy;
    assign sb.error_out       = errorQ;

endmodule
